// File: rtl/if_id_stage.sv
// IF/ID stage: owns the fetch PC, drives the I-cache, and holds the IF/ID
// pipeline register. Handles hazard stalls, flush redirects, and redirects
// that arrive during an I-cache miss. A redirect seen during a miss is
// parked in pend_pc until the miss clears. The fetch address must not change
// while the cache is still working on it.
module if_id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_stall,
   input  logic        hazard_flush,
   input  logic        hazard_mux,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic        ICACHE_stall,
   input  logic [31:0] ICACHE_rdata,
   output logic [31:0] ICACHE_addr,
   output logic        ICACHE_ren,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_inst,
   output logic        IF_ID_valid,
   output logic [6:0]  IF_ID_op,
   output logic [4:0]  IF_ID_rs1,
   output logic [4:0]  IF_ID_rs2,
   output logic [15:0] stall_cnt
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, PEND_REDIR} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
   } ifid_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pend_pc, pend_nxt;
   ifid_t       ifid, ifid_nxt;
   logic [15:0] cnt_nxt;
   logic        hold;
   logic        redir;
   logic [31:0] tgt;

   // A flush only counts when the hazard unit is not also holding the pipe.
   assign redir = hazard_flush & ~hazard_stall;
   assign tgt   = hazard_mux ? branch_target : jump_target;

   assign ICACHE_addr = pc;
   assign ICACHE_ren  = ~rst;

   assign IF_ID_pc    = ifid.pc;
   assign IF_ID_inst  = ifid.inst;
   assign IF_ID_valid = ifid.valid;
   assign IF_ID_op    = ifid.inst[6:0];
   assign IF_ID_rs1   = ifid.inst[19:15];
   assign IF_ID_rs2   = ifid.inst[24:20];

   // Next-state logic: PC update, IF/ID load/squash, pending redirect, stall count.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      pend_nxt  = pend_pc;
      ifid_nxt  = ifid;
      hold      = 1'b0;
      case (state)
         RUN: begin
            if (ICACHE_stall) begin
               // Address must stay put; remember the redirect for later.
               hold = 1'b1;
               if (redir) begin
                  pend_nxt       = tgt;
                  ifid_nxt.valid = 1'b0;
                  state_nxt      = PEND_REDIR;
               end
            end else if (hazard_stall) begin
               hold = 1'b1;
            end else if (hazard_flush) begin
               pc_nxt         = tgt;
               ifid_nxt.valid = 1'b0;
               ifid_nxt.inst  = NOP;
            end else begin
               pc_nxt   = pc + 32'd4;
               ifid_nxt = '{pc: pc, inst: ICACHE_rdata, valid: 1'b1};
            end
         end
         PEND_REDIR: begin
            if (ICACHE_stall) begin
               // Newest redirect wins while we are still waiting.
               hold = 1'b1;
               if (redir) pend_nxt = tgt;
            end else begin
               // Miss data belongs to the abandoned path; drop it.
               pc_nxt         = redir ? tgt : pend_pc;
               ifid_nxt.valid = 1'b0;
               ifid_nxt.inst  = NOP;
               state_nxt      = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
      cnt_nxt = (hold && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         pc        <= 32'h0;
         pend_pc   <= 32'h0;
         ifid      <= '{pc: 32'h0, inst: NOP, valid: 1'b0};
         stall_cnt <= 16'h0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         pend_pc   <= pend_nxt;
         ifid      <= ifid_nxt;
         stall_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic. The driver
// applies inputs on the falling edge, advances a behavioural model and queues
// the expected post-edge view; the monitor pops and compares after each
// rising edge.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst, hazard_stall, hazard_flush, hazard_mux, ICACHE_stall;
   logic [31:0] branch_target, jump_target, ICACHE_rdata;
   logic [31:0] ICACHE_addr, IF_ID_pc, IF_ID_inst;
   logic        ICACHE_ren, IF_ID_valid;
   logic [6:0]  IF_ID_op;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
      .hazard_mux(hazard_mux), .branch_target(branch_target), .jump_target(jump_target),
      .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
      .ICACHE_addr(ICACHE_addr), .ICACHE_ren(ICACHE_ren),
      .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid),
      .IF_ID_op(IF_ID_op), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic [31:0] ifpc;
      logic [31:0] inst;
      logic        valid;
      bit          pc_known;
      bit          inst_known;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model state: a fetch pointer, the latched IF/ID view, an
   // optional parked redirect and a plain integer count of held cycles.
   logic [31:0] m_pc, m_ifpc, m_inst, m_pendpc;
   logic        m_valid;
   bit          m_pend, m_pc_known, m_inst_known;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic hs, input logic hf, input logic hm,
                        input logic [31:0] bt, input logic [31:0] jt,
                        input logic ics, input logic [31:0] rd);
      logic [31:0] tgt;
      bit          redir;
      exp_t        e;
      @(negedge clk);
      rst = r; hazard_stall = hs; hazard_flush = hf; hazard_mux = hm;
      branch_target = bt; jump_target = jt; ICACHE_stall = ics; ICACHE_rdata = rd;
      tgt   = hm ? bt : jt;
      redir = hf && !hs;
      if (r) begin
         m_pc = 0; m_ifpc = 0; m_inst = 32'h13; m_valid = 0; m_pend = 0; m_pendpc = 0;
         m_cnt = 0; m_pc_known = 1; m_inst_known = 1;
      end else if (m_pend) begin
         if (ics) begin
            m_cnt++;
            if (redir) m_pendpc = tgt;
         end else begin
            m_pc = redir ? tgt : m_pendpc;
            m_valid = 0; m_pend = 0; m_pc_known = 0; m_inst_known = 0;
         end
      end else if (ics) begin
         m_cnt++;
         if (redir) begin
            m_pendpc = tgt; m_valid = 0; m_pend = 1; m_pc_known = 0;
         end
      end else if (hs) begin
         m_cnt++;
      end else if (hf) begin
         m_pc = tgt; m_valid = 0; m_inst = 32'h13; m_inst_known = 1; m_pc_known = 0;
      end else begin
         m_ifpc = m_pc; m_inst = rd; m_valid = 1; m_pc_known = 1; m_inst_known = 1;
         m_pc = m_pc + 32'd4;
      end
      e.rst = r; e.pc = m_pc; e.ifpc = m_ifpc; e.inst = m_inst; e.valid = m_valid;
      e.pc_known = m_pc_known; e.inst_known = m_inst_known;
      e.cnt = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      q.push_back(e);
   endtask

   // Convenience: a normal fetch cycle with given data.
   task automatic run(input logic [31:0] rd);
      cycle(0, 0, 0, 0, 32'h0, 32'h0, 0, rd);
   endtask

   // Monitor: compare the registered view just after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("icache_addr", ICACHE_addr, e.pc);
            check("icache_ren", {31'h0, ICACHE_ren}, {31'h0, ~e.rst});
            check("if_id_valid", {31'h0, IF_ID_valid}, {31'h0, e.valid});
            check("stall_cnt", {16'h0, stall_cnt}, {16'h0, e.cnt});
            if (e.pc_known) check("if_id_pc", IF_ID_pc, e.ifpc);
            if (e.inst_known) begin
               check("if_id_inst", IF_ID_inst, e.inst);
               check("if_id_op", {25'h0, IF_ID_op}, {25'h0, e.inst[6:0]});
               check("if_id_rs1", {27'h0, IF_ID_rs1}, {27'h0, e.inst[19:15]});
               check("if_id_rs2", {27'h0, IF_ID_rs2}, {27'h0, e.inst[24:20]});
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      rst = 1; hazard_stall = 0; hazard_flush = 0; hazard_mux = 0; ICACHE_stall = 0;
      branch_target = 0; jump_target = 0; ICACHE_rdata = 0;

      // Reset, with hazard inputs active to show reset wins.
      cycle(1, 1, 1, 1, 32'h44, 32'h88, 1, 32'h0);
      cycle(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

      // Straight-line fetch.
      run(32'hA); run(32'hB); run(32'hC);

      // Hazard stall for two cycles.
      cycle(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'hDEAD);
      cycle(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'hBEEF);

      // Branch redirect, then one fetch from the target.
      cycle(0, 0, 1, 1, 32'h100, 32'h999, 0, 32'h1111);
      run(32'h00C5_8533);

      // Flush together with stall: stall wins.
      cycle(0, 1, 1, 1, 32'h500, 32'h0, 0, 32'h2222);
      run(32'h0020_8093);

      // Cache miss for 4 cycles, jump redirect on the 2nd; targets wiggle afterwards.
      cycle(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h3333);
      cycle(0, 0, 1, 0, 32'h777, 32'h200, 1, 32'h3333);
      cycle(0, 0, 0, 0, 32'h888, 32'h999, 1, 32'h3333);
      cycle(0, 0, 0, 1, 32'hAAA, 32'hBBB, 1, 32'h3333);
      cycle(0, 0, 0, 0, 32'hCCC, 32'hDDD, 0, 32'h4444);
      run(32'h0041_0113); run(32'h0051_8193);

      // Redirect to the last word, then wrap to zero.
      cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
      run(32'h0000_0073); run(32'h0000_0001);

      // Reset while a redirect is pending loses the target.
      cycle(0, 0, 1, 0, 32'h0, 32'h300, 1, 32'h0);
      cycle(1, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
      run(32'h5); run(32'h6);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 18, 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom_range(0, 99) < 25, $urandom);
      end

      // Saturate the stall counter.
      cycle(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 65540; i++) cycle(0, 1, 0, 0, 32'h0, 32'h0, 0, $urandom);
      cycle(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0);
      run(32'h7);
      cycle(0, 0, 1, 0, 32'h0, 32'h40, 0, 32'h0);
      run(32'h8);

      // Let the monitor drain, bounded.
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      n_chk++;
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
